register_file_scanner: RTL and testbench
========================================

Name: register_file_scanner

Overview:
- Read-side companion to the 4x4 register file. Drives the file's read address and walks all entries in order.
- Captures each entry and holds it on the board LEDs, tagged with its address, for a fixed dwell time.
- Supports a single pass or continuous scanning. Gives a start/busy/done handshake to the board top level.

Parameters:
- DATA_WIDTH, 4, width of one register file entry.
- ADDR_WIDTH, 2, register file address width; entries scanned = 2**ADDR_WIDTH.
- DWELL_CYCLES, 25000000, clock cycles each captured entry is held (0.5 s at 50 MHz); legal range >= 1; the bench overrides it to 3.
- CNT_WIDTH, 25, dwell counter width; must hold DWELL_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clr_n  input  1  synchronous active-low reset.
- start  input  1  level; sampled only in IDLE; high starts a scan.
- cont  input  1  1 = continuous scan, 0 = single pass; sampled at the end of the last entry's dwell.
- rd_data  input  DATA_WIDTH  register file read data; combinational from r_address.
- r_address  output  ADDR_WIDTH  register file read address (registered).
- led_data  output  DATA_WIDTH  captured entry value.
- led_addr  output  ADDR_WIDTH  address of the captured entry.
- valid  output  1  led_data/led_addr hold a captured entry.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at the end of a single pass.

Behaviour:
- One clock domain: clk.
- Reset is synchronous, active-low on clr_n, evaluated at each rising edge. It has priority over everything, including mid-scan.
- Reset values: state=IDLE; r_address, led_data, led_addr, valid, busy, done, dwell counter = 0.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - busy=0, done=0; outputs retain their last captured values.
  - start=1 at an edge -> next state FETCH, r_address=0, busy=1.
- FETCH (exactly 1 cycle):
  - Gives the register file one cycle for the read.
  - At the edge: led_data<=rd_data, led_addr<=r_address, valid<=1, counter<=0 -> HOLD.
- HOLD:
  - Counter increments each cycle, so HOLD lasts exactly DWELL_CYCLES cycles.
  - On the edge where counter==DWELL_CYCLES-1:
    - r_address != last: r_address+1 -> FETCH.
    - r_address == last and cont=1: r_address wraps to 0 -> FETCH. There is no DONE and no gap.
    - r_address == last and cont=0: -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE. led_data, led_addr and valid persist.
- Per-entry period is DWELL_CYCLES+1 cycles. A single pass lasts 1 + 2**ADDR_WIDTH*(DWELL_CYCLES+1) cycles from the start edge to the DONE cycle inclusive.
- busy=1 throughout FETCH and HOLD.
- start is ignored while busy or in DONE. Holding start high re-triggers from IDLE on the cycle after DONE.
- cont is only looked at on the wrap decision. Dropping cont mid-pass ends the scan after the current pass.
- DWELL_CYCLES=1: HOLD lasts one cycle; period 2 cycles.
- Address increment is modulo 2**ADDR_WIDTH with no overflow flag.
- rd_data changing during HOLD does not affect led_data. It is captured only at the end of FETCH.

Test Plan:
Bench setup: DWELL_CYCLES=3; behavioural 4x4 file preloaded with A,5,3,C at addresses 0..3.
1. Reset: hold clr_n=0 for 2 edges with start=1 -> every output 0, busy=0. Release -> scan begins the next edge.
2. Single pass: start pulse at edge T, cont=0 ->
   - T+1: busy=1, r_address=0.
   - T+2: led_data=A, led_addr=0, valid=1.
   - T+6: led_data=5. T+10: led_data=3. T+14: led_data=C, led_addr=3.
   - T+17: done=1, busy=0. T+18: done=0; led_data stays C.
3. Continuous: cont=1, start pulse ->
   - Sequence A,5,3,C,A,5 every 4 cycles; done never asserts.
   - Drop cont during the second pass -> DONE 3 cycles after C is captured in that pass.
4. Start while busy: pulse start at T+7 during a single pass -> no restart; done still at T+17.
5. Reset mid-scan: clr_n=0 at T+9 -> at T+10 state IDLE, led_data=0, valid=0, busy=0. No done pulse.
6. Data change during HOLD: rewrite address 1 to F while led_data=5 is held -> led_data stays 5 until the next capture. The next pass shows F.

Source files
------------

// File: rtl/register_file_scanner.sv
// Register file scanner: walks every entry of a small register file, captures
// each one onto the LEDs together with its address, and holds it for a fixed
// dwell time. Supports a single pass or continuous scanning, with a
// start/busy/done handshake to the board top level.
module register_file_scanner #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter int DWELL_CYCLES = 25000000,
    parameter int CNT_WIDTH    = 25
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] r_address,
    output logic [DATA_WIDTH-1:0] led_data,
    output logic [ADDR_WIDTH-1:0] led_addr,
    output logic                  valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

    state_t                  state_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [ADDR_WIDTH-1:0]   r_address_q;
    logic [DATA_WIDTH-1:0]   led_data_q;
    logic [ADDR_WIDTH-1:0]   led_addr_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    dwell_end_d;
    logic                    last_entry_d;
    logic [ADDR_WIDTH-1:0]   addr_inc_d;

    // Decode the end of a dwell period, the last entry, and the next address
    // (the increment wraps naturally, which also covers continuous rescans).
    always_comb begin
        dwell_end_d  = (cnt_q == DWELL_LAST);
        last_entry_d = (r_address_q == ADDR_LAST);
        addr_inc_d   = r_address_q + ADDR_WIDTH'(1);
    end

    // Scan sequencer: all state and outputs are registered here.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_address_q <= '0;
            led_data_q  <= '0;
            led_addr_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= FETCH;
                        r_address_q <= '0;
                        busy_q      <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                FETCH: begin
                    // The address has been stable for one cycle, so the
                    // combinational read data is settled and can be captured.
                    led_data_q <= rd_data;
                    led_addr_q <= r_address_q;
                    valid_q    <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (dwell_end_d) begin
                        if (!last_entry_d || cont) begin
                            r_address_q <= addr_inc_d;
                            state_q     <= FETCH;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; a held start
                    // re-triggers from IDLE on the following edge.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign r_address = r_address_q;
    assign led_data  = led_data_q;
    assign led_addr  = led_addr_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_register_file_scanner.sv
// Testbench for register_file_scanner with a short dwell time and a small
// behavioural register file preloaded with A,5,3,C.
module tb_register_file_scanner;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int D  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          start;
    logic          cont;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] r_address;
    logic [DW-1:0] led_data;
    logic [AW-1:0] led_addr;
    logic          valid;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [4];
    logic [DW-1:0] pat [4];

    int checks   = 0;
    int failures = 0;

    register_file_scanner #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DWELL_CYCLES(D),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .cont     (cont),
        .rd_data  (rd_data),
        .r_address(r_address),
        .led_data (led_data),
        .led_addr (led_addr),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[r_address];

    // Reference model: tracks the scan as "which entry, how far through its
    // period" and derives the visible outputs from that.
    bit            m_active;
    bit            m_done;
    bit            m_valid;
    int            m_phase;
    int            m_entry;
    logic [DW-1:0] m_ledd;
    int            m_leda;

    always @(posedge clk) begin
        if (!clr_n) begin
            m_active = 0; m_done = 0; m_valid = 0;
            m_phase = 0; m_entry = 0; m_ledd = '0; m_leda = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_entry = 0; m_phase = 0;
            end
        end else if (m_phase == 0) begin
            m_ledd  = mem[m_entry];
            m_leda  = m_entry;
            m_valid = 1;
            m_phase = 1;
        end else if (m_phase < D) begin
            m_phase = m_phase + 1;
        end else begin
            m_phase = 0;
            if (m_entry != 3 || cont) m_entry = (m_entry + 1) % 4;
            else begin
                m_active = 0;
                m_done   = 1;
            end
        end
    end

    logic [10:0] obs;
    logic [10:0] exp_v;
    assign obs   = {r_address, led_data, led_addr, valid, busy, done};
    assign exp_v = {AW'(m_entry), m_ledd, AW'(m_leda), m_valid, m_active, m_done};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b1;
        cont  = 1'b0;
        tick();
        tick();
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", obs);
        end
        clr_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || r_address !== 2'd0) begin
            failures++;
            $display("FAIL reset_release busy=%b addr=%0d want busy=1 addr=0", busy, r_address);
        end
        start = 1'b0;
        do_reset();
    endtask

    task automatic test_single_pass();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || r_address !== 2'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL single_first busy=%b addr=%0d want busy=1 addr=0", busy, r_address);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL single_model k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if (k == 1 || k == 5 || k == 9 || k == 13) begin
                checks++;
                if (led_data !== pat[(k-1)/4] || led_addr !== AW'((k-1)/4) || valid !== 1'b1) begin
                    failures++;
                    $display("FAIL single_capture k=%0d got=%h@%0d want=%h@%0d",
                             k, led_data, led_addr, pat[(k-1)/4], (k-1)/4);
                end
            end
            checks++;
            if (done !== (k == 16) || busy !== (k < 16)) begin
                failures++;
                $display("FAIL single_handshake k=%0d done=%b busy=%b want done=%b busy=%b",
                         k, done, busy, k == 16, k < 16);
            end
        end
        checks++;
        if (led_data !== 4'hC || valid !== 1'b1) begin
            failures++;
            $display("FAIL single_persist got=%h valid=%b want=c valid=1", led_data, valid);
        end
    endtask

    task automatic test_continuous();
        bit saw_early_done;
        saw_early_done = 0;
        do_reset();
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 20) cont = 1'b0;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL cont_model k=%0d got=%h want=%h", k, obs, exp_v);
            end
            if ((k % 4) == 1 && k <= 29) begin
                checks++;
                if (led_data !== pat[((k-1)/4) % 4]) begin
                    failures++;
                    $display("FAIL cont_capture k=%0d got=%h want=%h", k, led_data, pat[((k-1)/4) % 4]);
                end
            end
            if (k < 32 && done) saw_early_done = 1;
            if (k == 32) begin
                checks++;
                if (done !== 1'b1 || led_data !== 4'hC) begin
                    failures++;
                    $display("FAIL cont_done k=32 done=%b led=%h want done=1 led=c", done, led_data);
                end
            end
        end
        checks++;
        if (saw_early_done) begin
            failures++;
            $display("FAIL cont_no_done got=1 want=0");
        end
    endtask

    task automatic test_start_busy();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            start = (k == 6);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL busy_model k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        saw_done = 0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=000", obs);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midreset_idle got=activity want=none");
        end
    endtask

    task automatic test_data_change();
        do_reset();
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 6) mem[1] = 4'hF;
            if (k >= 6 && k <= 8) begin
                checks++;
                if (led_data !== 4'h5) begin
                    failures++;
                    $display("FAIL hold_stable k=%0d got=%h want=5", k, led_data);
                end
            end
        end
        checks++;
        if (led_data !== 4'hF || led_addr !== 2'd1) begin
            failures++;
            $display("FAIL hold_newdata got=%h@%0d want=f@1", led_data, led_addr);
        end
        mem[1] = 4'h5;
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) cont = $urandom_range(0, 1);
            clr_n = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 3)] = DW'($urandom);
            tick();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_model k=%0d got=%h want=%h", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        pat[0] = 4'hA; pat[1] = 4'h5; pat[2] = 4'h3; pat[3] = 4'hC;
        for (int i = 0; i < 4; i++) mem[i] = pat[i];
        clr_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pass();
        test_continuous();
        test_start_busy();
        test_reset_mid();
        test_data_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
